// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core: RV32 major opcodes, the write-back
// FSM state type and the machine-mode ecall cause code.
package npc_pkg;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_CSR    = 7'b1110011;

  localparam int MCAUSE_ECALL_M = 11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_COMMIT   = 2'd2
  } wbu_state_t;

  // True for opcodes that write rd; SYSTEM only writes for real CSR ops
  // (func3 != 0 is folded into is_csr by the decoder).
  function automatic logic writes_rd(input logic [6:0] op, input logic is_csr);
    return (op == OPCODE_LUI)  || (op == OPCODE_AUIPC) || (op == OPCODE_JAL)    ||
           (op == OPCODE_JALR) || (op == OPCODE_LOAD)  || (op == OPCODE_OP_IMM) ||
           (op == OPCODE_OP)   || ((op == OPCODE_CSR) && is_csr);
  endfunction

endpackage

// File: rtl/csr_onehot_dec.sv
// Index to one-hot decoder for CSR write strobes. Indices outside the
// implemented slot range decode to all-zero so no slot is written.
module csr_onehot_dec #(
  parameter int N  = 6,
  parameter int AW = 3
) (
  input  logic          en,
  input  logic [AW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic in_range;

  assign in_range = (int'(idx) < N);

  // One strobe per implemented slot, gated by enable and range check
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = en && in_range && (idx == AW'(i));
    end
  end

endmodule

// File: rtl/wbu_commit.sv
// Multicycle write-back/commit stage. Accepts one instruction in IDLE,
// optionally waits for the LSU (bounded by MEM_TIMEOUT), then retires it in
// a single COMMIT cycle with registered RF/CSR strobes and next-PC.
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both high; in_ready is high only in IDLE.
module wbu_commit
  import npc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NR_CSR      = 6,
  parameter int CSR_AW      = 3,
  parameter int MEPC_IDX    = 1,
  parameter int MCAUSE_IDX  = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [6:0]             opcode,
  input  logic [4:0]             rd,
  input  logic [XLEN-1:0]        pc,
  input  logic [XLEN-1:0]        imm,
  input  logic [XLEN-1:0]        exu_res,
  input  logic [XLEN-1:0]        jalr_target,
  input  logic                   is_ecall,
  input  logic                   is_mret,
  input  logic                   is_csr,
  input  logic                   mem_access,
  input  logic                   is_load,
  input  logic [CSR_AW-1:0]      csr_waddr,
  input  logic [XLEN-1:0]        csr_wdata_in,
  input  logic [XLEN-1:0]        mtvec,
  input  logic [XLEN-1:0]        mepc,
  input  logic                   lsu_resp_valid,
  input  logic [XLEN-1:0]        lsu_rdata,
  output logic [XLEN-1:0]        mem_addr,
  output logic                   commit,
  output logic                   rf_wen,
  output logic [4:0]             rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  output logic [NR_CSR-1:0]      csr_we,
  output logic [NR_CSR*XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0]        next_pc,
  output logic                   mem_fault
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  wbu_state_t    state;
  logic [CW-1:0] cnt;

  // Latched instruction
  logic [6:0]        r_opcode;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_pc, r_imm, r_exu, r_jalr, r_mtvec, r_mepc, r_csr_wdata;
  logic              r_ecall, r_mret, r_csr, r_load;
  logic [CSR_AW-1:0] r_csr_waddr;

  // Source for commit computation: live inputs when committing straight
  // out of IDLE, latched copy when committing out of MEM_WAIT.
  logic [6:0]        s_opcode;
  logic [4:0]        s_rd;
  logic [XLEN-1:0]   s_pc, s_imm, s_exu, s_jalr, s_mtvec, s_mepc, s_csr_wdata;
  logic              s_ecall, s_mret, s_csr, s_load;
  logic [CSR_AW-1:0] s_csr_waddr;

  logic              timeout_hit, c_fault, go_commit, c_rf_wen, c_ecall_w;
  logic [XLEN-1:0]   c_next_pc, c_rf_wdata;
  logic [NR_CSR-1:0] dec_we, c_csr_we;

  assign in_ready    = (state == S_IDLE);
  assign timeout_hit = (cnt == CW'(MEM_TIMEOUT - 1));
  // A response in the timeout cycle wins over the fault
  assign c_fault     = (state == S_MEM_WAIT) && !lsu_resp_valid && timeout_hit;
  assign go_commit   = ((state == S_IDLE) && in_valid && !mem_access) ||
                       ((state == S_MEM_WAIT) && (lsu_resp_valid || timeout_hit));

  // Select live or latched instruction fields
  always_comb begin
    s_opcode = r_opcode;  s_rd = r_rd;      s_pc = r_pc;     s_imm = r_imm;
    s_exu = r_exu;        s_jalr = r_jalr;  s_mtvec = r_mtvec; s_mepc = r_mepc;
    s_csr_wdata = r_csr_wdata; s_ecall = r_ecall; s_mret = r_mret;
    s_csr = r_csr;        s_load = r_load;  s_csr_waddr = r_csr_waddr;
    if (state == S_IDLE) begin
      s_opcode = opcode;  s_rd = rd;        s_pc = pc;       s_imm = imm;
      s_exu = exu_res;    s_jalr = jalr_target; s_mtvec = mtvec; s_mepc = mepc;
      s_csr_wdata = csr_wdata_in; s_ecall = is_ecall; s_mret = is_mret;
      s_csr = is_csr;     s_load = is_load; s_csr_waddr = csr_waddr;
    end
  end

  csr_onehot_dec #(
    .N  (NR_CSR),
    .AW (CSR_AW)
  ) u_csr_dec (
    .en     (s_csr && !s_ecall && !s_mret && !c_fault),
    .idx    (s_csr_waddr),
    .onehot (dec_we)
  );

  // Commit-cycle values: next PC, RF write and CSR strobes
  always_comb begin
    if (c_fault)                                        c_next_pc = s_mtvec;
    else if (s_ecall)                                   c_next_pc = s_mtvec;
    else if (s_mret)                                    c_next_pc = s_mepc;
    else if (s_opcode == OPCODE_JAL)                    c_next_pc = s_pc + s_imm;
    else if (s_opcode == OPCODE_JALR)                   c_next_pc = s_jalr & ~XLEN'(1);
    else if ((s_opcode == OPCODE_BRANCH) && s_exu[0])   c_next_pc = s_pc + s_imm;
    else                                                c_next_pc = s_pc + XLEN'(4);

    c_rf_wen = !c_fault && (s_rd != 5'd0) && writes_rd(s_opcode, s_csr);
    if (s_load)                                                     c_rf_wdata = lsu_rdata;
    else if ((s_opcode == OPCODE_JAL) || (s_opcode == OPCODE_JALR)) c_rf_wdata = s_pc + XLEN'(4);
    else                                                            c_rf_wdata = s_exu;

    c_ecall_w = s_ecall && !c_fault;
    c_csr_we  = '0;
    for (int i = 0; i < NR_CSR; i++) begin
      c_csr_we[i] = c_ecall_w ? ((i == MEPC_IDX) || (i == MCAUSE_IDX)) : dec_we[i];
    end
  end

  // FSM, instruction latch, timeout counter and registered commit outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      commit    <= 1'b0;
      rf_wen    <= 1'b0;
      csr_we    <= '0;
      mem_fault <= 1'b0;
      next_pc   <= '0;
      mem_addr  <= '0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      csr_wdata <= '0;
    end else begin
      commit    <= 1'b0;
      rf_wen    <= 1'b0;
      csr_we    <= '0;
      mem_fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            r_opcode    <= opcode;      r_rd     <= rd;
            r_pc        <= pc;          r_imm    <= imm;
            r_exu       <= exu_res;     r_jalr   <= jalr_target;
            r_mtvec     <= mtvec;       r_mepc   <= mepc;
            r_csr_wdata <= csr_wdata_in;
            r_ecall     <= is_ecall;    r_mret   <= is_mret;
            r_csr       <= is_csr;      r_load   <= is_load;
            r_csr_waddr <= csr_waddr;
            mem_addr    <= exu_res;
            cnt         <= '0;
            state       <= mem_access ? S_MEM_WAIT : S_COMMIT;
          end
        end
        S_MEM_WAIT: begin
          cnt <= cnt + 1'b1;
          if (lsu_resp_valid || timeout_hit) state <= S_COMMIT;
        end
        S_COMMIT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
      if (go_commit) begin
        commit    <= 1'b1;
        rf_wen    <= c_rf_wen;
        rf_waddr  <= s_rd;
        rf_wdata  <= c_rf_wdata;
        csr_we    <= c_csr_we;
        mem_fault <= c_fault;
        next_pc   <= c_next_pc;
        for (int i = 0; i < NR_CSR; i++) begin
          if (c_ecall_w) begin
            if (i == MEPC_IDX)   csr_wdata[i*XLEN +: XLEN] <= s_pc;
            if (i == MCAUSE_IDX) csr_wdata[i*XLEN +: XLEN] <= XLEN'(MCAUSE_ECALL_M);
          end else if (|dec_we) begin
            csr_wdata[i*XLEN +: XLEN] <= s_csr_wdata;
          end
        end
      end
    end
  end

endmodule
